ram_cmd_master: RTL

RAM_CMD_MASTER -- requirements
Module: ram_cmd_master

---
 rtl/ram_cmd_pkg.sv | 25 ++
 rtl/ram_cmd_master_if.sv | 34 +++
 rtl/ram_cmd_timer.sv | 36 +++
 rtl/ram_cmd_master.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ram_cmd_pkg.sv
// Shared opcodes, FSM states and default widths for the RAM command master.
package ram_cmd_pkg;

    localparam int DEFAULT_ADDR_SIZE      = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;
    localparam int OPCODE_W               = 2;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

endpackage

// File: rtl/ram_cmd_master_if.sv
// Request/response handshake plus the RAM command-word port of the command master.
interface ram_cmd_master_if
    import ram_cmd_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
);

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_SIZE-1:0]   req_addr;
    logic [ADDR_SIZE-1:0]   req_wdata;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [ADDR_SIZE-1:0]   resp_rdata;
    logic                   resp_err;

    logic [ADDR_SIZE+1:0]   ram_din;
    logic                   ram_rx_valid;
    logic [ADDR_SIZE-1:0]   ram_dout;
    logic                   ram_tx_valid;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, ram_dout, ram_tx_valid,
        output req_ready, resp_valid, resp_rdata, resp_err, ram_din, ram_rx_valid
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, ram_dout, ram_tx_valid,
        input  req_ready, resp_valid, resp_rdata, resp_err, ram_din, ram_rx_valid
    );

endinterface

// File: rtl/ram_cmd_timer.sv
// Read-wait timeout counter: cleared outside the wait, counts wait cycles without data.
module ram_cmd_timer
    import ram_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_r;

    // wait-cycle counter, saturating at TIMEOUT_CYCLES
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != MAX_CNT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // high during the last permitted wait cycle: one more empty cycle reaches the limit
    assign expired = (count_r == LAST_CNT);

endmodule

// File: rtl/ram_cmd_master.sv
// Turns single read/write requests into RAM command words, waits for read data with a
// timeout and returns one response per request; repeated write addresses are not re-sent.
module ram_cmd_master
    import ram_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ADDR_SIZE      = DEFAULT_ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_cmd_master_if.master      bus
);

    localparam int WORD_W = ADDR_SIZE + OPCODE_W;

    function automatic logic [WORD_W-1:0] cmd_word(input opcode_t op,
                                                   input logic [ADDR_SIZE-1:0] payload);
        return {op, payload};
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;

    logic [ADDR_SIZE-1:0]   req_addr_r;
    logic [ADDR_SIZE-1:0]   req_wdata_r;
    logic [ADDR_SIZE-1:0]   cache_addr_r;
    logic                   cache_valid_r;

    logic [WORD_W-1:0]      ram_din_r;
    logic [WORD_W-1:0]      ram_din_next_s;
    logic                   ram_rx_valid_r;
    logic                   ram_rx_valid_next_s;
    logic                   resp_valid_r;
    logic [ADDR_SIZE-1:0]   resp_rdata_r;
    logic [ADDR_SIZE-1:0]   resp_rdata_next_s;
    logic                   resp_err_r;
    logic                   resp_err_next_s;

    logic                   accept_s;
    logic                   cache_hit_s;
    logic                   timer_clear_s;
    logic                   timer_enable_s;
    logic                   timer_expired_s;

    assign accept_s    = (state_r == ST_IDLE) && bus.req_valid;
    assign cache_hit_s = cache_valid_r && (cache_addr_r == bus.req_addr);

    ram_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (timer_expired_s)
    );

    // next state plus the next value of every registered output
    always_comb begin
        state_next_s        = state_r;
        ram_din_next_s      = {WORD_W{1'b0}};
        ram_rx_valid_next_s = 1'b0;
        resp_rdata_next_s   = {ADDR_SIZE{1'b0}};
        resp_err_next_s     = 1'b0;
        timer_clear_s       = 1'b1;
        timer_enable_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    ram_rx_valid_next_s = 1'b1;
                    if (!bus.req_write) begin
                        state_next_s   = ST_RD_ADDR;
                        ram_din_next_s = cmd_word(OP_RD_ADDR, bus.req_addr);
                    end else if (cache_hit_s) begin
                        state_next_s   = ST_WR_DATA;
                        ram_din_next_s = cmd_word(OP_WR_DATA, bus.req_wdata);
                    end else begin
                        state_next_s   = ST_WR_ADDR;
                        ram_din_next_s = cmd_word(OP_WR_ADDR, bus.req_addr);
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_ADDR: begin
                state_next_s        = ST_WR_DATA;
                ram_rx_valid_next_s = 1'b1;
                ram_din_next_s      = cmd_word(OP_WR_DATA, req_wdata_r);
            end
            ST_WR_DATA: begin
                state_next_s = ST_RESP;
            end
            ST_RD_ADDR: begin
                state_next_s        = ST_RD_DATA;
                ram_rx_valid_next_s = 1'b1;
                ram_din_next_s      = cmd_word(OP_RD_DATA, {ADDR_SIZE{1'b0}});
            end
            ST_RD_DATA: begin
                state_next_s = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                timer_clear_s = 1'b0;
                if (bus.ram_tx_valid) begin
                    state_next_s      = ST_RESP;
                    resp_rdata_next_s = bus.ram_dout;
                end else if (timer_expired_s) begin
                    timer_enable_s  = 1'b1;
                    state_next_s    = ST_RESP;
                    resp_err_next_s = 1'b1;
                end else begin
                    timer_enable_s = 1'b1;
                    state_next_s   = ST_RD_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s      = ST_RESP;
                    resp_rdata_next_s = resp_rdata_r;
                    resp_err_next_s   = resp_err_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // state register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            ram_din_r      <= {WORD_W{1'b0}};
            ram_rx_valid_r <= 1'b0;
            resp_valid_r   <= 1'b0;
            resp_rdata_r   <= {ADDR_SIZE{1'b0}};
            resp_err_r     <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            ram_din_r      <= ram_din_next_s;
            ram_rx_valid_r <= ram_rx_valid_next_s;
            resp_valid_r   <= (state_next_s == ST_RESP);
            resp_rdata_r   <= resp_rdata_next_s;
            resp_err_r     <= resp_err_next_s;
        end
    end

    // request latch and write-address cache; the cache follows issued WR_ADDR words only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_addr_r    <= {ADDR_SIZE{1'b0}};
            req_wdata_r   <= {ADDR_SIZE{1'b0}};
            cache_addr_r  <= {ADDR_SIZE{1'b0}};
            cache_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                req_addr_r  <= bus.req_addr;
                req_wdata_r <= bus.req_wdata;
            end else begin
                req_addr_r  <= req_addr_r;
                req_wdata_r <= req_wdata_r;
            end
            if (state_r == ST_WR_ADDR) begin
                cache_addr_r  <= req_addr_r;
                cache_valid_r <= 1'b1;
            end else begin
                cache_addr_r  <= cache_addr_r;
                cache_valid_r <= cache_valid_r;
            end
        end
    end

    // ready is held low while reset is asserted so no request is taken during reset
    assign bus.req_ready    = rst_n && (state_r == ST_IDLE);
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_rdata   = resp_rdata_r;
    assign bus.resp_err     = resp_err_r;
    assign bus.ram_din      = ram_din_r;
    assign bus.ram_rx_valid = ram_rx_valid_r;

endmodule
